// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with a built-in test-pattern source.
// Produces sync, data-enable, coordinates and RGB for the TMDS encoders.
`timescale 1ns/1ps

module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CE_DIV   = 4,
    parameter int CW       = 12
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [23:0]   rgb,
    output logic          sof,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    h_q, h_d, v_q, v_d;
    logic [7:0]       frame_q, frame_d;
    logic [1:0]       mode_q, mode_d;
    logic             pix_ce_q, pix_ce_d;
    logic             sof_q, sof_d;
    logic             de_q, de_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [CW-1:0]    x_q, x_d, y_q, y_d;
    logic [23:0]      rgb_q, rgb_d;

    logic             div_last, ce;
    logic             h_last, v_last, first_px, active_px, in_hs, in_vs;
    logic [1:0]       eff_mode;
    logic [CW+2:0]    h_x8;
    logic [2:0]       bar;
    logic [23:0]      bar_rgb, pattern_rgb;

    assign div_last  = (div_q == DIV_W'(CE_DIV - 1));
    assign ce        = enable && div_last;
    assign h_last    = (h_q == CW'(H_TOTAL - 1));
    assign v_last    = (v_q == CW'(V_TOTAL - 1));
    assign first_px  = (h_q == '0) && (v_q == '0);
    assign active_px = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    assign in_hs     = (h_q >= CW'(HS_START)) && (h_q < CW'(HS_END));
    assign in_vs     = (v_q >= CW'(VS_START)) && (v_q < CW'(VS_END));
    // The pixel that latches a new mode is already drawn in that mode.
    assign eff_mode  = first_px ? mode : mode_q;

    // Bar index = floor(x*8/H_ACTIVE) via constant thresholds, no divider.
    always_comb begin
        h_x8 = {h_q, 3'b000};
        bar  = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_x8 >= (CW+3)'(k * H_ACTIVE)) begin
                bar = 3'(k);
            end
        end
        case (bar)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
        case (eff_mode)
            2'd0:    pattern_rgb = solid_rgb;
            2'd1:    pattern_rgb = bar_rgb;
            2'd2:    pattern_rgb = (h_q[3] ^ v_q[3]) ? 24'hFFFFFF : 24'h000000;
            default: pattern_rgb = {8'(h_q) + frame_q, 8'(v_q), frame_q};
        endcase
    end

    always_comb begin
        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        frame_d  = frame_q;
        mode_d   = mode_q;
        pix_ce_d = ce;
        sof_d    = 1'b0;
        de_d     = de_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        x_d      = x_q;
        y_d      = y_q;
        rgb_d    = rgb_q;
        if (enable) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end
        if (ce) begin
            h_d = h_last ? '0 : h_q + CW'(1);
            if (h_last) begin
                v_d = v_last ? '0 : v_q + CW'(1);
                if (v_last) begin
                    frame_d = frame_q + 8'd1;
                end
            end
            if (first_px) begin
                mode_d = mode;
            end
            sof_d   = first_px;
            de_d    = active_px;
            hsync_d = in_hs ? HS_ACT : ~HS_ACT;
            vsync_d = in_vs ? VS_ACT : ~VS_ACT;
            x_d     = h_q;
            y_d     = v_q;
            rgb_d   = active_px ? pattern_rgb : 24'h000000;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            frame_q  <= 8'd0;
            mode_q   <= 2'd0;
            pix_ce_q <= 1'b0;
            sof_q    <= 1'b0;
            de_q     <= 1'b0;
            hsync_q  <= ~HS_ACT;
            vsync_q  <= ~VS_ACT;
            x_q      <= '0;
            y_q      <= '0;
            rgb_q    <= 24'h000000;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            frame_q  <= frame_d;
            mode_q   <= mode_d;
            pix_ce_q <= pix_ce_d;
            sof_q    <= sof_d;
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rgb_q    <= rgb_d;
        end
    end

    // Strobes vanish as soon as enable drops, even mid-cycle.
    assign pix_ce    = pix_ce_q & enable;
    assign sof       = sof_q & enable;
    assign de        = de_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign x         = x_q;
    assign y         = y_q;
    assign rgb       = rgb_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen: a small-raster instance (A, CE_DIV=4) and a
// 640-wide instance (B, CE_DIV=1, positive syncs) checked against a pixel-index model.
`timescale 1ns/1ps

module tb_video_timing_pattern_gen;

    localparam int CW = 12;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable;
    logic [1:0]    mode_w [2];
    logic [23:0]   solid_rgb;
    logic          pix_ce_w [2];
    logic          hsync_w  [2];
    logic          vsync_w  [2];
    logic          de_w     [2];
    logic          sof_w    [2];
    logic [CW-1:0] x_w      [2];
    logic [CW-1:0] y_w      [2];
    logic [23:0]   rgb_w    [2];
    logic [7:0]    fc_w     [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CE_DIV(4), .CW(CW)
    ) dut_a (
        .clk_fast(clk), .rst_n(rst_n), .enable(enable), .mode(mode_w[0]),
        .solid_rgb(solid_rgb), .pix_ce(pix_ce_w[0]), .hsync(hsync_w[0]),
        .vsync(vsync_w[0]), .de(de_w[0]), .x(x_w[0]), .y(y_w[0]),
        .rgb(rgb_w[0]), .sof(sof_w[0]), .frame_cnt(fc_w[0])
    );

    video_timing_pattern_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CE_DIV(1), .CW(CW)
    ) dut_b (
        .clk_fast(clk), .rst_n(rst_n), .enable(enable), .mode(mode_w[1]),
        .solid_rgb(solid_rgb), .pix_ce(pix_ce_w[1]), .hsync(hsync_w[1]),
        .vsync(vsync_w[1]), .de(de_w[1]), .x(x_w[1]), .y(y_w[1]),
        .rgb(rgb_w[1]), .sof(sof_w[1]), .frame_cnt(fc_w[1])
    );

    // Parameter table: 0 HA,1 HFP,2 HS,3 HBP,4 VA,5 VFP,6 VS,7 VBP,8 HPOL,9 VPOL,10 CE
    function automatic int cfg(input int d, input int k);
        int a [11];
        int b [11];
        a = '{8, 2, 3, 3, 4, 1, 2, 1, 0, 0, 4};
        b = '{640, 16, 96, 48, 4, 1, 2, 1, 1, 1, 1};
        return (d == 0) ? a[k] : b[k];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] ma, input logic [1:0] mb,
                                 input logic [23:0] sol);
        enable    = en;
        mode_w[0] = ma;
        mode_w[1] = mb;
        solid_rgb = sol;
    endtask

    // Model state: enabled-edge count, pixels emitted, and the outputs of the last pixel.
    int          m_edges [2];
    int          m_np    [2];
    bit          m_strobe[2];
    bit          m_first [2];
    int          m_mode  [2];
    logic        e_de    [2];
    logic        e_hs    [2];
    logic        e_vs    [2];
    logic [11:0] e_x     [2];
    logic [11:0] e_y     [2];
    logic [23:0] e_rgb   [2];
    logic [7:0]  e_fc    [2];

    // The model treats pixel n as the n-th strobe since reset and derives
    // h, v and frame number from it by plain division.
    always @(posedge clk or negedge rst_n) begin
        int n, ht, vt, ft, h, v, f, ha, va, hss, vss;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_edges[d] = 0; m_np[d] = 0; m_strobe[d] = 0; m_first[d] = 0; m_mode[d] = 0;
                e_de[d] = 0; e_hs[d] = !cfg(d, 8); e_vs[d] = !cfg(d, 9);
                e_x[d] = 0; e_y[d] = 0; e_rgb[d] = 0; e_fc[d] = 0;
            end else if (enable) begin
                m_edges[d]++;
                if (m_edges[d] % cfg(d, 10) == 0) begin
                    ha  = cfg(d, 0);
                    va  = cfg(d, 4);
                    ht  = ha + cfg(d, 1) + cfg(d, 2) + cfg(d, 3);
                    vt  = va + cfg(d, 5) + cfg(d, 6) + cfg(d, 7);
                    ft  = ht * vt;
                    n   = m_np[d];
                    h   = n % ht;
                    v   = (n / ht) % vt;
                    f   = (n / ft) % 256;
                    hss = ha + cfg(d, 1);
                    vss = va + cfg(d, 5);
                    m_first[d] = (h == 0 && v == 0);
                    if (m_first[d]) m_mode[d] = int'(mode_w[d]);
                    e_de[d]  = (h < ha) && (v < va);
                    e_hs[d]  = ((h >= hss) && (h < hss + cfg(d, 2))) ? cfg(d, 8) != 0 : cfg(d, 8) == 0;
                    e_vs[d]  = ((v >= vss) && (v < vss + cfg(d, 6))) ? cfg(d, 9) != 0 : cfg(d, 9) == 0;
                    e_x[d]   = 12'(h);
                    e_y[d]   = 12'(v);
                    e_fc[d]  = 8'(((n + 1) / ft) % 256);
                    e_rgb[d] = 24'h0;
                    if (e_de[d]) begin
                        case (m_mode[d])
                            0: e_rgb[d] = solid_rgb;
                            1: case ((h * 8) / ha)
                                   0: e_rgb[d] = 24'hFFFFFF;
                                   1: e_rgb[d] = 24'hFFFF00;
                                   2: e_rgb[d] = 24'h00FFFF;
                                   3: e_rgb[d] = 24'h00FF00;
                                   4: e_rgb[d] = 24'hFF00FF;
                                   5: e_rgb[d] = 24'hFF0000;
                                   6: e_rgb[d] = 24'h0000FF;
                                   default: e_rgb[d] = 24'h000000;
                               endcase
                            2: e_rgb[d] = ((((h / 8) + (v / 8)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
                            default: e_rgb[d] = {8'((h + f) % 256), 8'(v % 256), 8'(f)};
                        endcase
                    end
                    m_np[d]++;
                    m_strobe[d] = 1;
                end else begin
                    m_strobe[d] = 0;
                end
            end else begin
                m_strobe[d] = 0;
            end
        end
    end

    // Every falling edge: compare both instances against reset values or the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                checkOutput($sformatf("d%0d.rst.pix_ce", d), pix_ce_w[d], 0);
                checkOutput($sformatf("d%0d.rst.sof", d), sof_w[d], 0);
                checkOutput($sformatf("d%0d.rst.hsync", d), hsync_w[d], cfg(d, 8) == 0);
                checkOutput($sformatf("d%0d.rst.x", d), x_w[d], 0);
                checkOutput($sformatf("d%0d.rst.rgb", d), rgb_w[d], 0);
            end else begin
                checkOutput($sformatf("d%0d.pix_ce", d), pix_ce_w[d], m_strobe[d] && enable);
                checkOutput($sformatf("d%0d.sof", d), sof_w[d], m_strobe[d] && m_first[d] && enable);
                checkOutput($sformatf("d%0d.de", d), de_w[d], e_de[d]);
                checkOutput($sformatf("d%0d.hsync", d), hsync_w[d], e_hs[d]);
                checkOutput($sformatf("d%0d.vsync", d), vsync_w[d], e_vs[d]);
                checkOutput($sformatf("d%0d.x", d), x_w[d], e_x[d]);
                checkOutput($sformatf("d%0d.y", d), y_w[d], e_y[d]);
                checkOutput($sformatf("d%0d.rgb", d), rgb_w[d], e_rgb[d]);
                checkOutput($sformatf("d%0d.frame_cnt", d), fc_w[d], e_fc[d]);
            end
        end
    end

    // Directed sequence with hand-computed expectations. Pixel n of A is
    // visible at falling edge k = 4*(n+1) after release; pixel n of B at k = n+1.
    initial begin
        bit found;
        int wait_cnt;
        applyStimulus(1'b0, 2'd0, 2'd1, 24'h123456);
        repeat (3) @(negedge clk);
        checkOutput("lit.rst.a.vsync", vsync_w[0], 1);
        checkOutput("lit.rst.b.vsync", vsync_w[1], 0);
        checkOutput("lit.rst.a.frame", fc_w[0], 0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 2'd1, 24'h123456);

        for (int k = 1; k <= 6420; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    checkOutput("lit.b.first.pix_ce", pix_ce_w[1], 1);
                    checkOutput("lit.b.first.rgb", rgb_w[1], 24'hFFFFFF);
                end
                3:    checkOutput("lit.a.k3.pix_ce", pix_ce_w[0], 0);
                4: begin
                    checkOutput("lit.a.first.pix_ce", pix_ce_w[0], 1);
                    checkOutput("lit.a.first.sof", sof_w[0], 1);
                    checkOutput("lit.a.first.rgb", rgb_w[0], 24'h123456);
                end
                5:    checkOutput("lit.a.k5.pix_ce", pix_ce_w[0], 0);
                8:    checkOutput("lit.a.k8.sof", sof_w[0], 0);
                32:   checkOutput("lit.a.h7.de", de_w[0], 1);
                36:   checkOutput("lit.a.h8.de", de_w[0], 0);
                40:   checkOutput("lit.a.h9.hsync", hsync_w[0], 1);
                44:   checkOutput("lit.a.h10.hsync", hsync_w[0], 0);
                52:   checkOutput("lit.a.h12.hsync", hsync_w[0], 0);
                56:   checkOutput("lit.a.h13.hsync", hsync_w[0], 1);
                80:   checkOutput("lit.b.x79.rgb", rgb_w[1], 24'hFFFFFF);
                81:   checkOutput("lit.b.x80.rgb", rgb_w[1], 24'hFFFF00);
                148:  checkOutput("lit.a.after_change.rgb", rgb_w[0], 24'h123456);
                260:  checkOutput("lit.a.v4.vsync", vsync_w[0], 1);
                324:  checkOutput("lit.a.v5.vsync", vsync_w[0], 0);
                388:  checkOutput("lit.a.v6.vsync", vsync_w[0], 0);
                452:  checkOutput("lit.a.v7.vsync", vsync_w[0], 1);
                516: begin
                    checkOutput("lit.a.sof2", sof_w[0], 1);
                    checkOutput("lit.a.sof2.frame", fc_w[0], 1);
                    checkOutput("lit.a.sof2.rgb", rgb_w[0], 24'h010001);
                end
                520:  checkOutput("lit.a.f1x1.rgb", rgb_w[0], 24'h020001);
                640:  checkOutput("lit.b.x639.rgb", rgb_w[1], 24'h000000);
                641: begin
                    checkOutput("lit.b.x640.de", de_w[1], 0);
                    checkOutput("lit.b.x640.rgb", rgb_w[1], 24'h000000);
                end
                656:  checkOutput("lit.b.h655.hsync", hsync_w[1], 0);
                657:  checkOutput("lit.b.h656.hsync", hsync_w[1], 1);
                1605: checkOutput("lit.b.after_change.rgb", rgb_w[1], 24'hFFFFFF);
                6401: begin
                    checkOutput("lit.b.sof2", sof_w[1], 1);
                    checkOutput("lit.b.f1x0.rgb", rgb_w[1], 24'h000000);
                end
                6409: checkOutput("lit.b.f1x8.rgb", rgb_w[1], 24'hFFFFFF);
                6417: checkOutput("lit.b.f1x16.rgb", rgb_w[1], 24'h000000);
                default: ;
            endcase
            if (k == 144) begin
                #1 mode_w[0] = 2'd3;
            end
            if (k == 1604) begin
                #1 mode_w[1] = 2'd2;
            end
        end

        // Pause just after A shows pixel x=5, then resume.
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (pix_ce_w[0] === 1'b1 && x_w[0] === 12'd5) found = 1;
        end
        checkOutput("lit.a.pause.reached", found, 1);
        #1 enable = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            checkOutput("lit.pause.a.pix_ce", pix_ce_w[0], 0);
            checkOutput("lit.pause.b.pix_ce", pix_ce_w[1], 0);
            checkOutput("lit.pause.a.x", x_w[0], 5);
            checkOutput("lit.pause.a.hsync", hsync_w[0], 1);
        end
        #1 enable = 1'b1;
        found = 0;
        wait_cnt = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            wait_cnt++;
            if (pix_ce_w[0] === 1'b1) found = 1;
        end
        checkOutput("lit.resume.a.seen", found, 1);
        checkOutput("lit.resume.a.latency", wait_cnt, 4);
        checkOutput("lit.resume.a.x", x_w[0], 6);

        // Asynchronous reset between clock edges, then restart in mode 1.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("lit.async.a.x", x_w[0], 0);
        checkOutput("lit.async.a.hsync", hsync_w[0], 1);
        checkOutput("lit.async.b.hsync", hsync_w[1], 0);
        checkOutput("lit.async.a.rgb", rgb_w[0], 0);
        checkOutput("lit.async.a.frame", fc_w[0], 0);
        checkOutput("lit.async.a.pix_ce", pix_ce_w[0], 0);
        mode_w[0] = 2'd1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            case (k)
                4: begin
                    checkOutput("lit.restart.a.sof", sof_w[0], 1);
                    checkOutput("lit.restart.a.y", y_w[0], 0);
                    checkOutput("lit.restart.a.frame", fc_w[0], 0);
                    checkOutput("lit.restart.a.rgb", rgb_w[0], 24'hFFFFFF);
                end
                8:  checkOutput("lit.restart.a.x1.rgb", rgb_w[0], 24'hFFFF00);
                32: checkOutput("lit.restart.a.x7.rgb", rgb_w[0], 24'h000000);
                default: ;
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
